// File: rtl/axi3_mem_slave_if.sv
// AXI3 write/read channel bundle between a master and axi3_mem_slave.
interface axi3_mem_slave_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int NB = DATA_W / 8;

  logic [ID_W-1:0]   awid;
  logic [31:0]       awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [NB-1:0]     wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi3_mem_slave.sv
// AXI3 slave fronting a byte-addressable RAM with independent write and read
// burst engines (FIXED/INCR/WRAP, narrow beats, strobes, per-beat SLVERR).
module axi3_mem_slave #(
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_BYTES = 1024
) (
  input logic             clk,
  input logic             resetn,
  axi3_mem_slave_if.slave s
);
  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned AW      = $clog2(MEM_BYTES);
  localparam logic [2:0]  LOG_NB  = 3'($clog2(NB));
  localparam logic [32:0] MEM_END = 33'(MEM_BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic wrap_bad(input logic [31:0] a, input logic [2:0] size,
                                    input logic [1:0] burst, input logic [3:0] len);
    return (burst == 2'b10) &&
           (!(len inside {4'd1, 4'd3, 4'd7, 4'd15}) || ((a & ((32'd1 << size) - 32'd1)) != '0));
  endfunction

  function automatic logic beat_bad(input logic [31:0] a, input logic [2:0] size,
                                    input logic [1:0] burst, input logic wbad);
    logic [32:0] last;
    last = {1'b0, a & ~((32'd1 << size) - 32'd1)} + (33'd1 << size) - 33'd1;
    return (size > LOG_NB) || (burst == 2'b11) || wbad || (last >= MEM_END);
  endfunction

  // Illegal WRAP (wbad) falls back to INCR stepping.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [3:0] len,
                                            input logic wbad);
    logic [31:0] b, span, base;
    b    = 32'd1 << size;
    span = ({28'd0, len} + 32'd1) << size;
    base = a & ~(span - 32'd1);
    if (burst == 2'b00)               return a;
    else if (burst == 2'b10 && !wbad) return base + ((a + b - base) & (span - 32'd1));
    else                              return (a & ~(b - 32'd1)) + b;
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [31:0] a, input logic [2:0] size);
    logic [31:0]   b, lo, hi;
    logic [NB-1:0] m;
    b  = 32'd1 << size;
    lo = a & 32'(NB - 1);
    hi = lo + b - (a & (b - 32'd1));
    m  = '0;
    for (int unsigned l = 0; l < NB; l++) m[l] = (l >= lo) && (l < hi);
    return m;
  endfunction

  logic [7:0] mem [MEM_BYTES];

  // ---------------- write engine ----------------
  w_state_t        w_state_q;
  logic [31:0]     w_addr_q;
  logic [3:0]      w_len_q, w_beat_q;
  logic [2:0]      w_size_q;
  logic [1:0]      w_burst_q, bresp_q;
  logic            w_wbad_q, w_err_q, bvalid_q;
  logic [ID_W-1:0] bid_q;

  logic [31:0]     w_addr_d;
  logic            w_bad_d, w_last_d, w_err_d, w_fire;
  logic [NB-1:0]   w_mask_d;
  logic [AW-1:0]   w_row;

  always_comb begin
    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q, w_wbad_q);
    w_bad_d  = beat_bad(w_addr_q, w_size_q, w_burst_q, w_wbad_q);
    w_mask_d = lane_mask(w_addr_q, w_size_q);
    w_last_d = (w_beat_q == w_len_q);
    w_err_d  = w_err_q | w_bad_d | (s.wlast != w_last_d);
    w_fire   = s.wvalid && (w_state_q == W_DATA);
    w_row    = w_addr_q[AW-1:0] & ~AW'(NB - 1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_wbad_q  <= 1'b0;
      w_err_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
    end else begin
      unique case (w_state_q)
        W_IDLE: if (s.awvalid) begin
          bid_q     <= s.awid;
          w_addr_q  <= s.awaddr;
          w_len_q   <= s.awlen;
          w_size_q  <= s.awsize;
          w_burst_q <= s.awburst;
          w_wbad_q  <= wrap_bad(s.awaddr, s.awsize, s.awburst, s.awlen);
          w_beat_q  <= '0;
          w_err_q   <= 1'b0;
          w_state_q <= W_DATA;
        end
        W_DATA: if (s.wvalid) begin
          w_addr_q <= w_addr_d;
          w_beat_q <= w_beat_q + 4'd1;
          w_err_q  <= w_err_d;
          if (w_last_d) begin
            bvalid_q  <= 1'b1;
            bresp_q   <= w_err_d ? 2'b10 : 2'b00;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (s.bready) begin
          bvalid_q  <= 1'b0;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && !w_bad_d)
      for (int unsigned l = 0; l < NB; l++)
        if (w_mask_d[l] && s.wstrb[l]) mem[w_row + AW'(l)] <= s.wdata[8*l +: 8];
  end

  // ---------------- read engine ----------------
  r_state_t          r_state_q;
  logic [31:0]       r_addr_q;
  logic [3:0]        r_len_q, r_beat_q;
  logic [2:0]        r_size_q;
  logic [1:0]        r_burst_q, rresp_q;
  logic              r_wbad_q, rvalid_q, rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;

  // Beat to load: from AR in idle, else the successor of the current beat.
  logic [31:0]       ld_addr, r_nxt;
  logic [2:0]        ld_size;
  logic [1:0]        ld_burst;
  logic              ld_wbad, ld_bad;
  logic [NB-1:0]     ld_mask;
  logic [AW-1:0]     ld_row;
  logic [DATA_W-1:0] ld_data;

  always_comb begin
    r_nxt = next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q, r_wbad_q);
    if (r_state_q == R_IDLE) begin
      ld_addr  = s.araddr;
      ld_size  = s.arsize;
      ld_burst = s.arburst;
      ld_wbad  = wrap_bad(s.araddr, s.arsize, s.arburst, s.arlen);
    end else begin
      ld_addr  = r_nxt;
      ld_size  = r_size_q;
      ld_burst = r_burst_q;
      ld_wbad  = r_wbad_q;
    end
    ld_bad  = beat_bad(ld_addr, ld_size, ld_burst, ld_wbad);
    ld_mask = lane_mask(ld_addr, ld_size);
    ld_row  = ld_addr[AW-1:0] & ~AW'(NB - 1);
    ld_data = '0;
    for (int unsigned l = 0; l < NB; l++)
      if (ld_mask[l] && !ld_bad) ld_data[8*l +: 8] = mem[ld_row + AW'(l)];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_wbad_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: if (s.arvalid) begin
          rid_q     <= s.arid;
          r_addr_q  <= s.araddr;
          r_len_q   <= s.arlen;
          r_size_q  <= s.arsize;
          r_burst_q <= s.arburst;
          r_wbad_q  <= ld_wbad;
          r_beat_q  <= '0;
          rdata_q   <= ld_data;
          rresp_q   <= ld_bad ? 2'b10 : 2'b00;
          rlast_q   <= (s.arlen == 4'd0);
          rvalid_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: if (s.rready) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            r_state_q <= R_IDLE;
          end else begin
            r_addr_q <= r_nxt;
            r_beat_q <= r_beat_q + 4'd1;
            rdata_q  <= ld_data;
            rresp_q  <= ld_bad ? 2'b10 : 2'b00;
            rlast_q  <= ((r_beat_q + 4'd1) == r_len_q);
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  logic unused_wid;
  assign unused_wid = ^s.wid;

  assign s.awready = (w_state_q == W_IDLE);
  assign s.wready  = (w_state_q == W_DATA);
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.bid     = bid_q;
  assign s.arready = (r_state_q == R_IDLE);
  assign s.rvalid  = rvalid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.rlast   = rlast_q;
  assign s.rid     = rid_q;
endmodule
